masked_mant_mul: RTL and testbench
==================================

MASKED_MANT_MUL -- requirements
Module: masked_mant_mul

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: 12-bit significands, 11-bit mask, 24-bit product.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand set present on sig_a, sig_b and mask.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 sig_a  input  12  significand A as {hidden bit, fraction[10:0]}.
REQ-007 sig_b  input  12  significand B, same format as sig_a.
REQ-008 mask  input  11  precision mask from the precision controller; bit 10 is the fraction MSB.
REQ-009 out_valid  output  1  product and trunc are valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 product  output  24  masked sig_a times masked sig_b, unsigned.
REQ-012 trunc  output  1  at least one masked-off fraction bit of either operand was 1.

Function
REQ-013 Effective width bw (0..11) SHALL be the count of consecutive 1s in mask, starting at bit 10; bits below the first 0 are ignored.
- Non-thermometer mask example: 11'b10100000000 gives bw=1.
- All-zero mask gives bw=0.
REQ-014 Effective mask SHALL be {1'b1, bw ones, (11-bw) zeros}; the hidden bit is always kept.
REQ-015 Both operands SHALL be ANDed with the effective mask at acceptance.
REQ-016 trunc SHALL be the OR of all operand bits cleared by the effective mask.
REQ-017 product SHALL equal the exact 24-bit product of the masked operands; no rounding.
REQ-018 FSM states SHALL be IDLE, BUSY and DONE.
REQ-019 IDLE: in_ready=1. An acceptance is in_valid&&in_ready at a rising edge; it latches the masked operands, bw and trunc, clears the accumulator, sets the bit counter to bw, and moves to BUSY.
REQ-020 BUSY: in_ready=0. Each cycle SHALL process one bit of masked B, MSB-first from bit 11 down to bit 11-bw.
- Update: acc <= (acc<<1) + (bit ? masked A : 0).
REQ-021 BUSY SHALL last exactly bw+1 cycles.
- On the last BUSY cycle, acc shifted left by (11-bw) SHALL be loaded into product and the FSM moves to DONE.
- Latency: acceptance at edge k gives out_valid=1 after edge k+bw+2 (2 to 13 cycles).
REQ-022 DONE: out_valid=1, in_ready=0. product and trunc SHALL hold stable until out_valid&&out_ready at an edge; the FSM then returns to IDLE.
REQ-023 The block SHALL NOT accept new operands in the same cycle as a result handshake; in_ready rises the cycle after leaving DONE.
REQ-024 in_valid SHALL be ignored outside IDLE. Operand, mask and out_ready changes during BUSY SHALL NOT affect the computation in flight.
REQ-025 out_valid SHALL be a registered output. Only one operation SHALL be in flight; there is no pipelining.

Reset
REQ-026 While rst_n=0, outputs SHALL be: state IDLE, in_ready=1, out_valid=0, product=0, trunc=0; accumulator and counter cleared.
REQ-027 Reset asserted mid-BUSY or mid-DONE SHALL abort the operation immediately, without waiting for an edge; the aborted result is never presented.
REQ-028 After rst_n deasserts, the first acceptance SHALL be possible at the first rising edge.

Verification
REQ-029 mask=11'h7FF, sig_a=12'hFFF, sig_b=12'hFFF -> product=24'hFFE001, trunc=0, out_valid 13 cycles after acceptance.
REQ-030 mask=11'b11110000000, sig_a=12'hFFF, sig_b=12'h800 -> product=24'h7C0000, trunc=1, out_valid 6 cycles after acceptance.
REQ-031 mask=11'h000, sig_a=12'hABC, sig_b=12'h801 -> product=24'h400000, trunc=1, out_valid 2 cycles after acceptance.
REQ-032 mask=11'b10100000000, sig_a=sig_b=12'hC00 -> bw=1, product=24'h900000, trunc=0, out_valid 3 cycles after acceptance.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> product, trunc and out_valid stay stable, in_ready stays 0. Then out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
REQ-034 Reset mid-BUSY of the REQ-029 operation -> out_valid=0, product=0, in_ready=1 at once. A new operation started after release completes with correct values and latency.

Source files
------------

// File: rtl/masked_mant_mul_if.sv
// Handshake bus for the masked significand multiplier.
// The master drives operands and out_ready; the slave returns the result.
interface masked_mant_mul_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] sig_a;
  logic [11:0] sig_b;
  logic [10:0] mask;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] product;
  logic        trunc;

  modport master (
    output in_valid, sig_a, sig_b, mask, out_ready,
    input  in_ready, out_valid, product, trunc
  );

  modport slave (
    input  in_valid, sig_a, sig_b, mask, out_ready,
    output in_ready, out_valid, product, trunc
  );
endinterface

// File: rtl/masked_mant_mul.sv
// Serial shift-and-add multiplier for 12-bit significands with a precision mask.
//
// state | meaning
// IDLE  | waiting for an operand set, in_ready=1
// BUSY  | one bit of masked B per cycle, MSB first, bw+1 cycles
// DONE  | result held until out_valid && out_ready
//
// The product register loads on the final BUSY edge; out_valid is a flop that
// rises one edge later, so the result is presented from settled registers.
module masked_mant_mul (
  input  logic             clk,
  input  logic             rst_n,
  masked_mant_mul_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] a_q, a_d;
  logic [11:0] b_sh_q, b_sh_d;
  logic [23:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  bw_q, bw_d;
  logic        trunc_pend_q, trunc_pend_d;
  logic [23:0] product_q, product_d;
  logic        trunc_q, trunc_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready;

  logic [10:0] frac_keep;
  logic [3:0]  bw_in;
  logic        run;
  logic [11:0] eff_mask;
  logic [11:0] a_m;
  logic [11:0] b_m;
  logic        trunc_in;
  logic        accept;
  logic        handshake;
  logic        last_bit;
  logic [23:0] acc_nxt;

  // Thermometer decode of the mask: keep bits from bit 10 down to the first 0.
  always_comb begin
    run       = 1'b1;
    bw_in     = 4'd0;
    frac_keep = 11'd0;
    for (int i = 10; i >= 0; i--) begin
      if (run && bus.mask[i]) begin
        frac_keep[i] = 1'b1;
        bw_in        = bw_in + 4'd1;
      end else begin
        run = 1'b0;
      end
    end
  end

  assign eff_mask  = {1'b1, frac_keep};
  assign a_m       = bus.sig_a & eff_mask;
  assign b_m       = bus.sig_b & eff_mask;
  assign trunc_in  = |((bus.sig_a | bus.sig_b) & ~eff_mask);

  assign accept    = (state_q == IDLE) && bus.in_valid;
  assign handshake = out_valid_q && bus.out_ready;
  assign last_bit  = (state_q == BUSY) && (cnt_q == 4'd0);
  assign acc_nxt   = {acc_q[22:0], 1'b0} + (b_sh_q[11] ? {12'd0, a_q} : 24'd0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = BUSY;
      BUSY:    if (last_bit)  state_d = DONE;
      DONE:    if (handshake) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready = (state_q == IDLE);
  end

  // Datapath next values: operand capture, serial accumulate, result load.
  always_comb begin
    a_d          = a_q;
    b_sh_d       = b_sh_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    bw_d         = bw_q;
    trunc_pend_d = trunc_pend_q;
    product_d    = product_q;
    trunc_d      = trunc_q;
    out_valid_d  = (state_q == DONE) && !handshake;
    if (accept) begin
      a_d          = a_m;
      b_sh_d       = b_m;
      acc_d        = 24'd0;
      cnt_d        = bw_in;
      bw_d         = bw_in;
      trunc_pend_d = trunc_in;
    end else if (state_q == BUSY) begin
      acc_d  = acc_nxt;
      b_sh_d = {b_sh_q[10:0], 1'b0};
      if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        // Re-align: only the top bw+1 bits of B were consumed.
        product_d = acc_nxt << (4'd11 - bw_q);
        trunc_d   = trunc_pend_q;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= 12'd0;
      b_sh_q       <= 12'd0;
      acc_q        <= 24'd0;
      cnt_q        <= 4'd0;
      bw_q         <= 4'd0;
      trunc_pend_q <= 1'b0;
      product_q    <= 24'd0;
      trunc_q      <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      a_q          <= a_d;
      b_sh_q       <= b_sh_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      bw_q         <= bw_d;
      trunc_pend_q <= trunc_pend_d;
      product_q    <= product_d;
      trunc_q      <= trunc_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.trunc     = trunc_q;

endmodule

// File: tb/tb_masked_mant_mul.sv
module tb_masked_mant_mul;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  masked_mant_mul_if bus();

  masked_mant_mul dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Present one operand set, then wait (bounded) for out_valid.
  task automatic do_op(input logic [11:0] a, input logic [11:0] b, input logic [10:0] m,
                       output int lat, output logic [23:0] prod, output logic tr);
    bus.sig_a     = a;
    bus.sig_b     = b;
    bus.mask      = m;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
    prod = bus.product;
    tr   = bus.trunc;
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat; logic [23:0] p; logic t;
    #2;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.product !== 24'h0) begin failures++; $display("FAIL rst_product: got %h expected 000000", bus.product); end
    checks++; if (bus.trunc !== 1'b0) begin failures++; $display("FAIL rst_trunc: got %b expected 0", bus.trunc); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(12'hABC, 12'h801, 11'h000, lat, p, t);
    checks++; if (lat !== 2) begin failures++; $display("FAIL first_accept_lat: got %0d expected 2", lat); end
    checks++; if (p !== 24'h400000) begin failures++; $display("FAIL first_accept_product: got %h expected 400000", p); end
    finish_op();
  endtask

  task automatic test_full_width();
    int lat;
    bus.sig_a = 12'hFFF; bus.sig_b = 12'hFFF; bus.mask = 11'h7FF;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL full_accepted: in_ready got %b expected 0", bus.in_ready); end
    // Disturb every input while the operation is in flight.
    bus.sig_a = 12'h000; bus.sig_b = 12'h000; bus.mask = 11'h000;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      bus.out_ready = n[0];
      if (bus.out_valid === 1'b1) begin lat = n; break; end
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    checks++; if (lat !== 13) begin failures++; $display("FAIL full_lat: got %0d expected 13", lat); end
    checks++; if (bus.product !== 24'hFFE001) begin failures++; $display("FAIL full_product: got %h expected FFE001", bus.product); end
    checks++; if (bus.trunc !== 1'b0) begin failures++; $display("FAIL full_trunc: got %b expected 0", bus.trunc); end
    finish_op();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL full_release_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL full_release_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_partial();
    int lat; logic [23:0] p; logic t;
    do_op(12'hFFF, 12'h800, 11'b11110000000, lat, p, t);
    checks++; if (lat !== 6) begin failures++; $display("FAIL partial_lat: got %0d expected 6", lat); end
    checks++; if (p !== 24'h7C0000) begin failures++; $display("FAIL partial_product: got %h expected 7C0000", p); end
    checks++; if (t !== 1'b1) begin failures++; $display("FAIL partial_trunc: got %b expected 1", t); end
    finish_op();
  endtask

  task automatic test_zero_mask();
    int lat; logic [23:0] p; logic t;
    do_op(12'hABC, 12'h801, 11'h000, lat, p, t);
    checks++; if (lat !== 2) begin failures++; $display("FAIL zero_lat: got %0d expected 2", lat); end
    checks++; if (p !== 24'h400000) begin failures++; $display("FAIL zero_product: got %h expected 400000", p); end
    checks++; if (t !== 1'b1) begin failures++; $display("FAIL zero_trunc: got %b expected 1", t); end
    finish_op();
  endtask

  task automatic test_non_thermometer();
    int lat; logic [23:0] p; logic t;
    do_op(12'hC00, 12'hC00, 11'b10100000000, lat, p, t);
    checks++; if (lat !== 3) begin failures++; $display("FAIL nontherm_lat: got %0d expected 3", lat); end
    checks++; if (p !== 24'h900000) begin failures++; $display("FAIL nontherm_product: got %h expected 900000", p); end
    checks++; if (t !== 1'b0) begin failures++; $display("FAIL nontherm_trunc: got %b expected 0", t); end
    finish_op();
  endtask

  task automatic test_mid_width();
    int lat; logic [23:0] p; logic t;
    do_op(12'hB6D, 12'hC3A, 11'b11111100000, lat, p, t);
    checks++; if (lat !== 8) begin failures++; $display("FAIL mid_lat: got %0d expected 8", lat); end
    checks++; if (p !== 24'h89EC00) begin failures++; $display("FAIL mid_product: got %h expected 89EC00", p); end
    checks++; if (t !== 1'b1) begin failures++; $display("FAIL mid_trunc: got %b expected 1", t); end
    finish_op();
  endtask

  task automatic test_backpressure();
    int lat; logic [23:0] p; logic t;
    do_op(12'hA55, 12'h9F0, 11'b11000000000, lat, p, t);
    checks++; if (lat !== 4) begin failures++; $display("FAIL bp_lat: got %0d expected 4", lat); end
    checks++; if (p !== 24'h500000) begin failures++; $display("FAIL bp_product: got %h expected 500000", p); end
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = ~bus.in_valid;
      bus.sig_a = bus.sig_a + 12'h135;
      bus.sig_b = bus.sig_b ^ 12'hFFF;
      bus.mask  = 11'h7FF;
      @(posedge clk); #1;
      checks++; if (bus.product !== 24'h500000) begin failures++; $display("FAIL bp_hold_product[%0d]: got %h expected 500000", c, bus.product); end
      checks++; if (bus.trunc !== 1'b1) begin failures++; $display("FAIL bp_hold_trunc[%0d]: got %b expected 1", c, bus.trunc); end
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", c, bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_ready[%0d]: got %b expected 0", c, bus.in_ready); end
    end
    // in_valid stays high across the handshake edge: it must not be accepted there.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [23:0] p; logic t;
    do_op(12'h800, 12'hFFF, 11'h7FF, lat, p, t);
    checks++; if (lat !== 13) begin failures++; $display("FAIL b2b_1_lat: got %0d expected 13", lat); end
    checks++; if (p !== 24'h7FF800) begin failures++; $display("FAIL b2b_1_product: got %h expected 7FF800", p); end
    checks++; if (t !== 1'b0) begin failures++; $display("FAIL b2b_1_trunc: got %b expected 0", t); end
    finish_op();
    do_op(12'hFFF, 12'hFFF, 11'b11111111110, lat, p, t);
    checks++; if (lat !== 12) begin failures++; $display("FAIL b2b_2_lat: got %0d expected 12", lat); end
    checks++; if (p !== 24'hFFC004) begin failures++; $display("FAIL b2b_2_product: got %h expected FFC004", p); end
    checks++; if (t !== 1'b1) begin failures++; $display("FAIL b2b_2_trunc: got %b expected 1", t); end
    finish_op();
  endtask

  task automatic test_reset_mid_busy();
    int lat; logic [23:0] p; logic t;
    bus.sig_a = 12'hFFF; bus.sig_b = 12'hFFF; bus.mask = 11'h7FF;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rbusy_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.product !== 24'h0) begin failures++; $display("FAIL rbusy_product: got %h expected 000000", bus.product); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rbusy_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(12'hFFF, 12'h800, 11'b11110000000, lat, p, t);
    checks++; if (lat !== 6) begin failures++; $display("FAIL rbusy_new_lat: got %0d expected 6", lat); end
    checks++; if (p !== 24'h7C0000) begin failures++; $display("FAIL rbusy_new_product: got %h expected 7C0000", p); end
    checks++; if (t !== 1'b1) begin failures++; $display("FAIL rbusy_new_trunc: got %b expected 1", t); end
    finish_op();
  endtask

  task automatic test_reset_mid_done();
    int lat; logic [23:0] p; logic t;
    int seen;
    do_op(12'hABC, 12'h801, 11'h000, lat, p, t);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rdone_pre_valid: got %b expected 1", bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rdone_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.trunc !== 1'b0) begin failures++; $display("FAIL rdone_trunc: got %b expected 0", bus.trunc); end
    checks++; if (bus.product !== 24'h0) begin failures++; $display("FAIL rdone_product: got %h expected 000000", bus.product); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rdone_aborted_presented: got %0d valid cycles expected 0", seen); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.sig_a     = 12'h000;
    bus.sig_b     = 12'h000;
    bus.mask      = 11'h000;
    test_reset();
    test_full_width();
    test_partial();
    test_zero_mask();
    test_non_thermometer();
    test_mid_width();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    test_reset_mid_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
